pes_checksum_seq: RTL

- Streaming sequencer for the 16-bit ones-complement (Internet) checksum datapath.
- Accepts a packet as a stream of 32-bit words over a valid/ready handshake and accumulates both 16-bit halves of each word.
- Folds the end-around carries in a dedicated state, then presents the inverted 16-bit checksum on a valid/ready output.
- Sits between a packet-buffer reader and the header-insert/verify logic.

---
 rtl/pes_checksum_seq_if.sv | 33 +++
 rtl/pes_checksum_seq.sv | 93 +++++++++
 2 files changed

// File: rtl/pes_checksum_seq_if.sv
// pes_checksum_seq_if: packet-word input stream and checksum result handshake; PES_CHECKSUM_KEEP_EN adds in_keep
interface pes_checksum_seq_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
`ifdef PES_CHECKSUM_KEEP_EN
    logic [3:0]  in_keep;
`endif
    logic [15:0] out_checksum;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
`ifdef PES_CHECKSUM_KEEP_EN
    modport master (
        output in_data, in_valid, in_last, in_keep, out_ready,
        input  in_ready, out_checksum, out_err, out_valid
    );
    modport slave (
        input  in_data, in_valid, in_last, in_keep, out_ready,
        output in_ready, out_checksum, out_err, out_valid
    );
`else
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_checksum, out_err, out_valid
    );
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_checksum, out_err, out_valid
    );
`endif
endinterface

// File: rtl/pes_checksum_seq.sv
// pes_checksum_seq: streaming 16-bit ones-complement checksum sequencer; PES_CHECKSUM_KEEP_EN enables byte masking via in_keep
module pes_checksum_seq #(
    parameter int ACC_W = 32
) (
    input logic           clk,
    input logic           rst_n,
    pes_checksum_seq_if.slave bus
);
    localparam int CNT_W = ACC_W - 16;
    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(2 ** (ACC_W - 17));

    typedef enum logic [1:0] {IDLE, ACCUM, FOLD, DONE} state_t;

    state_t           state, state_n;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             err;
    logic [15:0]      cs_q;
    logic             err_q;
    logic [31:0]      data;
    logic [ACC_W-1:0] add;
    logic             beat;
    logic             fold_done;

`ifdef PES_CHECKSUM_KEEP_EN
    assign data = bus.in_data & {{8{bus.in_keep[3]}}, {8{bus.in_keep[2]}},
                                 {8{bus.in_keep[1]}}, {8{bus.in_keep[0]}}};
`else
    assign data = bus.in_data;
`endif
    assign add              = ACC_W'(data[31:16]) + ACC_W'(data[15:0]);
    assign beat             = bus.in_valid && bus.in_ready;
    assign fold_done        = acc[ACC_W-1:16] == '0;
    assign bus.out_checksum = cs_q;
    assign bus.out_err      = err_q;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // next-state: one packet at a time, folding until the high bits are clear
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = beat ? (bus.in_last ? FOLD : ACCUM) : IDLE;
            ACCUM:   state_n = (beat && bus.in_last) ? FOLD : ACCUM;
            FOLD:    state_n = fold_done ? DONE : FOLD;
            DONE:    state_n = bus.out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // handshake outputs decoded purely from state
    always_comb begin
        bus.in_ready  = (state == IDLE) || (state == ACCUM);
        bus.out_valid = state == DONE;
    end

    // accumulate, freeze on overflow, fold end-around carries, latch the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
            err   <= 1'b0;
            cs_q  <= 16'h0000;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (beat) begin
                    acc   <= add;
                    count <= CNT_W'(1);
                    err   <= 1'b0;
                end
                ACCUM: if (beat) begin
                    if (count == MAX_WORDS) err <= 1'b1;
                    else begin
                        acc   <= acc + add;
                        count <= count + CNT_W'(1);
                    end
                end
                FOLD: if (!fold_done) acc <= ACC_W'(acc[15:0]) + ACC_W'(acc[ACC_W-1:16]);
                      else begin
                          cs_q  <= ~acc[15:0];
                          err_q <= err;
                      end
                DONE: if (bus.out_ready) acc <= '0;
                default: acc <= '0;
            endcase
        end
    end
endmodule
